itch_msg_serializer: RTL and testbench
======================================

// Module: itch_msg_serializer
// PURPOSE
// - Transmit side of the ITCH byte-stream interface: takes one parsed message (type plus fields) per handshake.
// - Emits it big-endian, one byte per beat, on the message/valid/start_msg/end_msg stream that the parser consumes.
// - Sits between the order-generation/replay logic and the parser or link, and produces the parser's loopback stimulus.
// PARAMETERS
// - MAX_LEN     36  bytes in the frame buffer; equals the longest supported message ('A').
// - GAP_CYCLES  1   minimum idle cycles (in_ready low, valid low) after end_msg before the next accept. 0 is legal.
// PORTS
// - clk           in   1   system clock; all logic on posedge
// - rst_n         in   1   asynchronous, active-low reset
// - in_valid      in   1   field bundle below is valid
// - in_ready      out  1   serializer can accept a bundle
// - msg_type      in   8   ASCII type: 'A'(41h), 'D'(44h), 'E'(45h), 'X'(58h)
// - stock_locate  in   16
// - tracking_no   in   16
// - timestamp     in   48
// - order_ref_no  in   64
// - shares        in   32  executed/cancelled shares for 'E'/'X'
// - buy_sell      in   8
// - stock         in   64
// - price         in   32
// - match_no      in   64
// - message       out  8   current byte
// - valid         out  1   message byte valid
// - start_msg     out  1   first byte of message (qualified by valid)
// - end_msg       out  1   last byte of message (qualified by valid)
// - out_ready     in   1   downstream takes byte when valid & out_ready
// - unsupported   out  1   1-cycle pulse: accepted bundle had an unknown msg_type
// - msg_count     out  32  messages fully sent (end byte taken), wraps at 2^32
// BEHAVIOUR
// - Reset (async assert, sync release): state IDLE, in_ready=0 while rst_n low and 1 from the first edge after release.
//   valid, start_msg, end_msg, unsupported all 0; message=0; msg_count=0.
// - FSM states: IDLE -> SEND -> GAP -> IDLE. in_ready = (state==IDLE).
// - IDLE: accept on in_valid & in_ready.
//   - Known type: load frame buffer MSB-first, set len, go to SEND. First byte is valid the next cycle (1-cycle latency).
//   - Unknown type: pulse unsupported the next cycle, nothing emitted, stay IDLE.
// - Frame layout, byte 0 first, multi-byte fields big-endian:
//   - A (36): type, locate, tracking, timestamp, order_ref, buy_sell, shares, stock, price
//   - E (31): type, locate, tracking, timestamp, order_ref, shares, match_no
//   - X (23): type, locate, tracking, timestamp, order_ref, shares
//   - D (19): type, locate, tracking, timestamp, order_ref
// - SEND: valid=1; message=buffer[top byte]; start_msg=(idx==0); end_msg=(idx==len-1).
//   - Byte taken (valid & out_ready): shift buffer by 8, idx++.
//   - out_ready low: message/start/end held stable, valid stays 1.
//   - Last byte taken: msg_count++; go to GAP, or straight to IDLE if GAP_CYCLES==0.
// - GAP: counter runs GAP_CYCLES cycles with valid=0, then IDLE.
// - A D message of length 1 is impossible; start_msg and end_msg are never high on the same byte.
// - Inputs are sampled only at accept; changes to the field inputs during SEND do not affect the frame in flight.
// - Reset mid-message: outputs drop immediately and the partial frame is abandoned (no end_msg).
//   msg_count does not count it.
// STRUCTURE
// - itch_pkg: msg-type constants (MSG_ADD, MSG_DEL, MSG_EXEC, MSG_CANCEL), per-type length constants,
//   and a function msg_len(type) returning 0 for unsupported types.
// - Sub-module itch_frame_pack (combinational): types/fields -> MAX_LEN*8-bit left-justified frame plus len.
// - Top level holds the FSM, shift buffer, idx/gap counters and msg_count.
// TESTING
// - Send 'A' bundle (locate 0102h, tracking 0304h, ts 000102030405h, ref AABBCCDDEEFF1122h, buy_sell 42h,
//   shares 00001000h, stock "STOCK   ", price 00010203h) with out_ready=1:
//   -> 36 consecutive bytes 41,01,02,...,00,01,02,03; start on byte 0, end on byte 35; msg_count=1.
// - Same 'A' bundle looped into the parser -> parser's valid_msg fires with every field equal to the bundle.
// - Send 'D' then 'E' back-to-back with GAP_CYCLES=1:
//   -> 19 bytes, exactly 1 idle cycle, then 31 bytes ending with match_no bytes; msg_count=2.
// - out_ready toggles randomly during 'X' -> 23 bytes in order, each held stable while stalled, no duplicates or drops.
// - msg_type=5Ah -> unsupported pulses once, valid never rises, in_ready is back high next cycle, msg_count unchanged.
// - Assert rst_n at byte 10 of 'A' -> valid=0 immediately. After release, a new 'D' is sent cleanly starting with start_msg.

Source files
------------

// File: rtl/itch_pkg.sv
// Shared ITCH message-type codes, frame lengths and FSM state encoding
// for the transmit-side serializer.
package itch_pkg;

    localparam logic [7:0] MSG_ADD    = 8'h41;
    localparam logic [7:0] MSG_DEL    = 8'h44;
    localparam logic [7:0] MSG_EXEC   = 8'h45;
    localparam logic [7:0] MSG_CANCEL = 8'h58;

    localparam int LEN_ADD    = 36;
    localparam int LEN_DEL    = 19;
    localparam int LEN_EXEC   = 31;
    localparam int LEN_CANCEL = 23;

    localparam int ITCH_MAX_LEN = 36;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } ser_state_e;

    // Zero marks an unsupported type; every supported frame is longer than one byte.
    function automatic logic [7:0] msg_len(input logic [7:0] msg_type);
        case (msg_type)
            MSG_ADD:    return 8'(LEN_ADD);
            MSG_DEL:    return 8'(LEN_DEL);
            MSG_EXEC:   return 8'(LEN_EXEC);
            MSG_CANCEL: return 8'(LEN_CANCEL);
            default:    return 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/itch_frame_pack.sv
// Combinational packer: field bundle -> left-justified big-endian frame
// (byte 0 in the top bits) plus its byte length.
module itch_frame_pack
    import itch_pkg::*;
#(
    parameter int MAX_LEN = ITCH_MAX_LEN
) (
    input  logic [7:0]           msg_type,
    input  logic [15:0]          stock_locate,
    input  logic [15:0]          tracking_no,
    input  logic [47:0]          timestamp,
    input  logic [63:0]          order_ref_no,
    input  logic [31:0]          shares,
    input  logic [7:0]           buy_sell,
    input  logic [63:0]          stock,
    input  logic [31:0]          price,
    input  logic [63:0]          match_no,
    output logic [MAX_LEN*8-1:0] frame,
    output logic [7:0]           len
);

    localparam int FW = MAX_LEN * 8;

    logic [LEN_DEL*8-1:0]    hdr_bits;
    logic [LEN_ADD*8-1:0]    add_bits;
    logic [LEN_EXEC*8-1:0]   exec_bits;
    logic [LEN_CANCEL*8-1:0] cancel_bits;

    assign hdr_bits    = {msg_type, stock_locate, tracking_no, timestamp, order_ref_no};
    assign add_bits    = {hdr_bits, buy_sell, shares, stock, price};
    assign exec_bits   = {hdr_bits, shares, match_no};
    assign cancel_bits = {hdr_bits, shares};

    always_comb begin
        len   = msg_len(msg_type);
        frame = '0;
        case (msg_type)
            MSG_ADD:    frame = FW'(add_bits)    << (FW - LEN_ADD * 8);
            MSG_EXEC:   frame = FW'(exec_bits)   << (FW - LEN_EXEC * 8);
            MSG_CANCEL: frame = FW'(cancel_bits) << (FW - LEN_CANCEL * 8);
            MSG_DEL:    frame = FW'(hdr_bits)    << (FW - LEN_DEL * 8);
            default:    frame = '0;
        endcase
    end

endmodule

// File: rtl/itch_msg_serializer.sv
// ITCH transmit serializer: accepts one field bundle per handshake and
// streams it big-endian, one byte per beat, with start/end markers.
//
// state | meaning
// IDLE  | in_ready high, waiting for a bundle
// SEND  | presenting buffer top byte, shifting on each taken byte
// GAP   | enforced idle cycles after end_msg before the next accept
module itch_msg_serializer
    import itch_pkg::*;
#(
    parameter int MAX_LEN    = ITCH_MAX_LEN,
    parameter int GAP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  msg_type,
    input  logic [15:0] stock_locate,
    input  logic [15:0] tracking_no,
    input  logic [47:0] timestamp,
    input  logic [63:0] order_ref_no,
    input  logic [31:0] shares,
    input  logic [7:0]  buy_sell,
    input  logic [63:0] stock,
    input  logic [31:0] price,
    input  logic [63:0] match_no,
    output logic [7:0]  message,
    output logic        valid,
    output logic        start_msg,
    output logic        end_msg,
    input  logic        out_ready,
    output logic        unsupported,
    output logic [31:0] msg_count
);

    localparam int FW    = MAX_LEN * 8;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    ser_state_e       state_q;
    logic [FW-1:0]    frame;
    logic [FW-1:0]    shift_q;
    logic [7:0]       frame_len;
    logic [7:0]       len_q;
    logic [7:0]       idx_q;
    logic [GAP_W-1:0] gap_cnt_q;
    logic             last_byte;

    itch_frame_pack #(.MAX_LEN(MAX_LEN)) u_pack (
        .msg_type     (msg_type),
        .stock_locate (stock_locate),
        .tracking_no  (tracking_no),
        .timestamp    (timestamp),
        .order_ref_no (order_ref_no),
        .shares       (shares),
        .buy_sell     (buy_sell),
        .stock        (stock),
        .price        (price),
        .match_no     (match_no),
        .frame        (frame),
        .len          (frame_len)
    );

    // Byte on the wire is always the buffer top; it drains to zero as the frame shifts out.
    assign message   = shift_q[FW-1 -: 8];
    assign last_byte = (idx_q == len_q - 8'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            len_q       <= 8'd0;
            idx_q       <= 8'd0;
            gap_cnt_q   <= '0;
            in_ready    <= 1'b0;
            valid       <= 1'b0;
            start_msg   <= 1'b0;
            end_msg     <= 1'b0;
            unsupported <= 1'b0;
            msg_count   <= 32'd0;
        end else begin
            unsupported <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        if (frame_len != 8'd0) begin
                            shift_q   <= frame;
                            len_q     <= frame_len;
                            idx_q     <= 8'd0;
                            state_q   <= ST_SEND;
                            in_ready  <= 1'b0;
                            valid     <= 1'b1;
                            start_msg <= 1'b1;
                            end_msg   <= 1'b0;
                        end else begin
                            unsupported <= 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    if (out_ready) begin
                        shift_q   <= shift_q << 8;
                        start_msg <= 1'b0;
                        if (last_byte) begin
                            msg_count <= msg_count + 32'd1;
                            valid     <= 1'b0;
                            end_msg   <= 1'b0;
                            idx_q     <= 8'd0;
                            if (GAP_CYCLES == 0) begin
                                state_q  <= ST_IDLE;
                                in_ready <= 1'b1;
                            end else begin
                                state_q   <= ST_GAP;
                                gap_cnt_q <= GAP_W'(GAP_CYCLES - 1);
                            end
                        end else begin
                            idx_q   <= idx_q + 8'd1;
                            end_msg <= (idx_q + 8'd2 == len_q);
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == '0) begin
                        state_q  <= ST_IDLE;
                        in_ready <= 1'b1;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    in_ready <= 1'b0;
                    valid    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_itch_msg_serializer.sv
// Bench for itch_msg_serializer: scoreboard of expected bytes fed from a field
// model, a type table, and hand sequences for gap, stall and reset cases.
module tb_itch_msg_serializer;
    import itch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  msg_type = 8'd0;
    logic [15:0] stock_locate = 16'd0;
    logic [15:0] tracking_no = 16'd0;
    logic [47:0] timestamp = 48'd0;
    logic [63:0] order_ref_no = 64'd0;
    logic [31:0] shares = 32'd0;
    logic [7:0]  buy_sell = 8'd0;
    logic [63:0] stock = 64'd0;
    logic [31:0] price = 32'd0;
    logic [63:0] match_no = 64'd0;
    logic [7:0]  message;
    logic        valid;
    logic        start_msg;
    logic        end_msg;
    logic        out_ready = 1'b1;
    logic        unsupported;
    logic [31:0] msg_count;

    itch_msg_serializer #(.MAX_LEN(36), .GAP_CYCLES(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .msg_type     (msg_type),
        .stock_locate (stock_locate),
        .tracking_no  (tracking_no),
        .timestamp    (timestamp),
        .order_ref_no (order_ref_no),
        .shares       (shares),
        .buy_sell     (buy_sell),
        .stock        (stock),
        .price        (price),
        .match_no     (match_no),
        .message      (message),
        .valid        (valid),
        .start_msg    (start_msg),
        .end_msg      (end_msg),
        .out_ready    (out_ready),
        .unsupported  (unsupported),
        .msg_count    (msg_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  t;
        logic [15:0] loc;
        logic [15:0] trk;
        logic [47:0] ts;
        logic [63:0] ref_no;
        logic [31:0] shr;
        logic [7:0]  bs;
        logic [63:0] stk;
        logic [31:0] prc;
        logic [63:0] mtch;
    } bundle_t;

    typedef struct {
        logic [7:0] b;
        logic       s;
        logic       e;
    } beat_t;

    typedef struct {
        logic [7:0] t;
        int         exp_len;
        logic       exp_unsup;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    beat_t       exp_q[$];
    beat_t       mon_e;
    logic [7:0]  cap[$];
    logic [7:0]  mdl[$];
    int          bytes_taken = 0;
    bit          rand_ready = 1'b0;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_msg = 8'd0;
    logic        prev_s = 1'b0;
    logic        prev_e = 1'b0;
    bit          after_end = 1'b0;
    int          idle_total = 0;
    int          idle_gap = 0;
    int          last_idle_total = -1;
    int          last_idle_gap = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Byte monitor: out_ready is decided on the falling edge, so a byte seen
    // here with valid & out_ready is exactly the one taken at the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
            after_end  = 1'b0;
        end else begin
            if (rand_ready) out_ready = ($urandom_range(0, 1) == 1);
            if (prev_stall) begin
                check("stall_valid", 64'(valid), 64'd1);
                check("stall_msg", 64'(message), 64'(prev_msg));
                check("stall_start", 64'(start_msg), 64'(prev_s));
                check("stall_end", 64'(end_msg), 64'(prev_e));
            end
            if (valid) begin
                if (after_end) begin
                    last_idle_total = idle_total;
                    last_idle_gap   = idle_gap;
                    after_end       = 1'b0;
                end
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: got %0h expected none", message);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("byte", 64'(message), 64'(mon_e.b));
                        check("start", 64'(start_msg), 64'(mon_e.s));
                        check("end", 64'(end_msg), 64'(mon_e.e));
                    end
                    cap.push_back(message);
                    bytes_taken++;
                    if (end_msg) begin
                        after_end  = 1'b1;
                        idle_total = 0;
                        idle_gap   = 0;
                    end
                end
            end else if (after_end) begin
                idle_total++;
                if (!in_ready) idle_gap++;
            end
            prev_stall = valid && !out_ready;
            prev_msg   = message;
            prev_s     = start_msg;
            prev_e     = end_msg;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic bundle_t rand_bundle(input logic [7:0] t);
        bundle_t b;
        logic [63:0] r;
        b.t      = t;
        r        = rand64();
        b.loc    = r[15:0];
        b.trk    = r[31:16];
        r        = rand64();
        b.ts     = r[47:0];
        b.ref_no = rand64();
        b.shr    = $urandom();
        r        = rand64();
        b.bs     = r[7:0];
        b.stk    = rand64();
        b.prc    = $urandom();
        b.mtch   = rand64();
        return b;
    endfunction

    task automatic add_field(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) mdl.push_back(v[8*i +: 8]);
    endtask

    task automatic push_model(input bundle_t b);
        beat_t bt;
        mdl.delete();
        if (b.t == 8'h41 || b.t == 8'h44 || b.t == 8'h45 || b.t == 8'h58) begin
            add_field(64'(b.t), 1);
            add_field(64'(b.loc), 2);
            add_field(64'(b.trk), 2);
            add_field(64'(b.ts), 6);
            add_field(b.ref_no, 8);
            case (b.t)
                8'h41: begin
                    add_field(64'(b.bs), 1);
                    add_field(64'(b.shr), 4);
                    add_field(b.stk, 8);
                    add_field(64'(b.prc), 4);
                end
                8'h45: begin
                    add_field(64'(b.shr), 4);
                    add_field(b.mtch, 8);
                end
                8'h58: add_field(64'(b.shr), 4);
                default: ;
            endcase
        end
        for (int i = 0; i < mdl.size(); i++) begin
            bt.b = mdl[i];
            bt.s = (i == 0);
            bt.e = (i == mdl.size() - 1);
            exp_q.push_back(bt);
        end
    endtask

    task automatic apply(input bundle_t b);
        msg_type     = b.t;
        stock_locate = b.loc;
        tracking_no  = b.trk;
        timestamp    = b.ts;
        order_ref_no = b.ref_no;
        shares       = b.shr;
        buy_sell     = b.bs;
        stock        = b.stk;
        price        = b.prc;
        match_no     = b.mtch;
    endtask

    // Returns one cycle after the accepting edge; fields are then scrambled
    // so a frame that re-samples them mid-flight shows up as a byte error.
    task automatic send_bundle(input bundle_t b);
        int n = 0;
        while (!in_ready && n < 300) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1");
        end else begin
            apply(b);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            apply(rand_bundle(b.t));
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!(exp_q.size() == 0 && in_ready && !valid) && n < 500) begin
            tick();
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: pending %0d expected 0", exp_q.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: sim time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        bundle_t    a_b;
        bundle_t    b;
        beat_t      bt;
        logic [7:0] a_exp [36];
        vec_t       vecs [7];
        int         base_bytes;
        logic [31:0] base_cnt;
        int         n;

        a_exp = '{8'h41, 8'h01, 8'h02, 8'h03, 8'h04,
                  8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                  8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h11, 8'h22,
                  8'h42, 8'h00, 8'h00, 8'h10, 8'h00,
                  8'h53, 8'h54, 8'h4F, 8'h43, 8'h4B, 8'h20, 8'h20, 8'h20,
                  8'h00, 8'h01, 8'h02, 8'h03};
        vecs[0] = '{8'h41, 36, 1'b0};
        vecs[1] = '{8'h44, 19, 1'b0};
        vecs[2] = '{8'h45, 31, 1'b0};
        vecs[3] = '{8'h58, 23, 1'b0};
        vecs[4] = '{8'h5A, 0, 1'b1};
        vecs[5] = '{8'h00, 0, 1'b1};
        vecs[6] = '{8'h61, 0, 1'b1};

        // Reset values
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_start_end", 64'({start_msg, end_msg}), 64'd0);
        check("rst_unsupported", 64'(unsupported), 64'd0);
        check("rst_message", 64'(message), 64'd0);
        check("rst_msg_count", 64'(msg_count), 64'd0);
        rst_n = 1'b1;
        tick();
        check("rel_in_ready", 64'(in_ready), 64'd1);

        // Reference 'A' bundle, hand-computed byte stream and field reassembly
        a_b = '{8'h41, 16'h0102, 16'h0304, 48'h000102030405, 64'hAABBCCDDEEFF1122,
                32'h00001000, 8'h42, 64'h53544F434B202020, 32'h00010203, 64'd0};
        for (int i = 0; i < 36; i++) begin
            bt.b = a_exp[i];
            bt.s = (i == 0);
            bt.e = (i == 35);
            exp_q.push_back(bt);
        end
        cap.delete();
        send_bundle(a_b);
        check("a_first_valid", 64'({valid, start_msg}), 64'b11);
        wait_done();
        check("a_bytes", 64'(cap.size()), 64'd36);
        check("a_msg_count", 64'(msg_count), 64'd1);
        if (cap.size() == 36) begin
            check("a_type", 64'(cap[0]), 64'h41);
            check("a_locate", 64'({cap[1], cap[2]}), 64'h0102);
            check("a_tracking", 64'({cap[3], cap[4]}), 64'h0304);
            check("a_timestamp", 64'({cap[5], cap[6], cap[7], cap[8], cap[9], cap[10]}), 64'h000102030405);
            check("a_order_ref", {cap[11], cap[12], cap[13], cap[14], cap[15], cap[16], cap[17], cap[18]}, 64'hAABBCCDDEEFF1122);
            check("a_buy_sell", 64'(cap[19]), 64'h42);
            check("a_shares", 64'({cap[20], cap[21], cap[22], cap[23]}), 64'h00001000);
            check("a_stock", {cap[24], cap[25], cap[26], cap[27], cap[28], cap[29], cap[30], cap[31]}, 64'h53544F434B202020);
            check("a_price", 64'({cap[32], cap[33], cap[34], cap[35]}), 64'h00010203);
        end

        // 'D' then 'E' back-to-back: one gap cycle plus the accept cycle
        base_cnt = msg_count;
        b = rand_bundle(8'h44);
        push_model(b);
        send_bundle(b);
        b = rand_bundle(8'h45);
        push_model(b);
        send_bundle(b);
        wait_done();
        check("de_gap_cycles", 64'(last_idle_gap), 64'd1);
        check("de_idle_cycles", 64'(last_idle_total), 64'd2);
        check("de_msg_count", 64'(msg_count - base_cnt), 64'd2);

        // 'X' with random back-pressure
        base_bytes = bytes_taken;
        b = rand_bundle(8'h58);
        push_model(b);
        rand_ready = 1'b1;
        send_bundle(b);
        wait_done();
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        check("x_bytes", 64'(bytes_taken - base_bytes), 64'd23);

        // Type table, out_ready held high
        for (int v = 0; v < 7; v++) begin
            base_bytes = bytes_taken;
            base_cnt   = msg_count;
            b = rand_bundle(vecs[v].t);
            push_model(b);
            send_bundle(b);
            check($sformatf("tbl%0d_unsupported", v), 64'(unsupported), 64'(vecs[v].exp_unsup));
            check($sformatf("tbl%0d_first_valid", v), 64'(valid), 64'(vecs[v].exp_len != 0));
            if (vecs[v].exp_unsup) begin
                check($sformatf("tbl%0d_in_ready", v), 64'(in_ready), 64'd1);
                tick();
                check($sformatf("tbl%0d_unsup_drop", v), 64'(unsupported), 64'd0);
            end
            wait_done();
            check($sformatf("tbl%0d_bytes", v), 64'(bytes_taken - base_bytes), 64'(vecs[v].exp_len));
            check($sformatf("tbl%0d_count", v), 64'(msg_count - base_cnt), 64'(vecs[v].exp_len != 0));
        end

        // Reset while byte 10 of an 'A' is on the wire
        base_bytes = bytes_taken;
        b = rand_bundle(8'h41);
        push_model(b);
        send_bundle(b);
        n = 0;
        while (bytes_taken - base_bytes < 10 && n < 100) begin
            tick();
            n++;
        end
        check("mid_bytes_before_rst", 64'(bytes_taken - base_bytes), 64'd10);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(valid), 64'd0);
        check("mid_rst_end", 64'(end_msg), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        check("mid_rst_count", 64'(msg_count), 64'd0);
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("mid_rel_in_ready", 64'(in_ready), 64'd1);
        b = rand_bundle(8'h44);
        push_model(b);
        send_bundle(b);
        check("mid_d_start", 64'({valid, start_msg}), 64'b11);
        wait_done();
        check("mid_d_count", 64'(msg_count), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
